// File: rtl/ttl_sync_updown_counter_pkg.sv
// Shared constants for the LS counter family: default LS delays,
// next-state op codes and parameter range checks.
package ttl_sync_updown_counter_pkg;

   localparam int LS_TPLH_MIN  = 0;
   localparam int LS_TPLH_TYP  = 13;
   localparam int LS_TPLH_MAX  = 24;
   localparam int LS_TPHL_MIN  = 0;
   localparam int LS_TPHL_TYP  = 18;
   localparam int LS_TPHL_MAX  = 27;
   localparam int LS_TPLHR_MIN = 0;
   localparam int LS_TPLHR_TYP = 20;
   localparam int LS_TPLHR_MAX = 35;
   localparam int LS_TPHLR_MIN = 0;
   localparam int LS_TPHLR_TYP = 18;
   localparam int LS_TPHLR_MAX = 35;

   typedef enum logic [1:0] {
      OP_HOLD,
      OP_COUNT,
      OP_LOAD,
      OP_RST
   } cnt_op_e;

   function automatic bit modulus_ok(input int width, input int modulus);
      return (width >= 1) && (width < 31) &&
             (modulus >= 2) && (modulus <= (1 << width));
   endfunction

   function automatic bit delays_ok(input int mn, input int ty, input int mx);
      return (mn >= 0) && (mn <= ty) && (ty <= mx);
   endfunction

endpackage

// File: rtl/ttl_cnt_next.sv
// Combinational next-state for a modulo-N up/down counter.
// Shared by the synchronous and the '190/'191-style models.
module ttl_cnt_next
   import ttl_sync_updown_counter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16
) (
   input  logic [WIDTH-1:0] cnt,
   input  logic             up,
   output logic [WIDTH-1:0] nxt,
   output logic             term
);

   // One extra bit keeps MODULUS = 2**WIDTH free of wrap artefacts.
   localparam logic [WIDTH:0] LAST = (WIDTH+1)'(MODULUS - 1);

   logic [WIDTH:0] ext;

   assign ext = {1'b0, cnt};

   always_comb begin
      nxt = cnt;
      unique case (1'b1)
         up && (ext >= LAST):  nxt = '0;
         up && (ext < LAST):   nxt = WIDTH'(ext + 1'b1);
         !up && (ext == '0):   nxt = WIDTH'(LAST);
         default:              nxt = WIDTH'(ext - 1'b1);
      endcase
   end

   assign term = up ? (ext == LAST) : (ext == '0);

endmodule

// File: rtl/ttl_sync_updown_counter.sv
// Synchronous up/down counter ('160/'161/'163/'168/'169 class).
// Define LSTTL_CNT_TIMING_EN to drive q/rco through LS delays.
module ttl_sync_updown_counter
   import ttl_sync_updown_counter_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int MODULUS   = 16,
   parameter int tPLH_min  = LS_TPLH_MIN,
   parameter int tPLH_typ  = LS_TPLH_TYP,
   parameter int tPLH_max  = LS_TPLH_MAX,
   parameter int tPHL_min  = LS_TPHL_MIN,
   parameter int tPHL_typ  = LS_TPHL_TYP,
   parameter int tPHL_max  = LS_TPHL_MAX,
   parameter int tPLHR_min = LS_TPLHR_MIN,
   parameter int tPLHR_typ = LS_TPLHR_TYP,
   parameter int tPLHR_max = LS_TPLHR_MAX,
   parameter int tPHLR_min = LS_TPHLR_MIN,
   parameter int tPHLR_typ = LS_TPHLR_TYP,
   parameter int tPHLR_max = LS_TPHLR_MAX
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_n,
   input  logic [WIDTH-1:0] d,
   input  logic             ep,
   input  logic             et,
   input  logic             up,
   output logic [WIDTH-1:0] q,
   output logic             rco
);

   if (!modulus_ok(WIDTH, MODULUS) ||
       !delays_ok(tPLH_min, tPLH_typ, tPLH_max) ||
       !delays_ok(tPHL_min, tPHL_typ, tPHL_max) ||
       !delays_ok(tPLHR_min, tPLHR_typ, tPLHR_max) ||
       !delays_ok(tPHLR_min, tPHLR_typ, tPHLR_max)) begin : g_bad_param
      $error("ttl_sync_updown_counter: bad WIDTH/MODULUS/delay parameters");
   end

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] nxt;
   logic             term;
   logic             rco_i;
   cnt_op_e          op;

   ttl_cnt_next #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_next (
      .cnt  (cnt),
      .up   (up),
      .nxt  (nxt),
      .term (term)
   );

   always_comb begin
      op = OP_HOLD;
      if (rst)
         op = OP_RST;
      else if (!load_n)
         op = OP_LOAD;
      else if (ep && et)
         op = OP_COUNT;
   end

   // No power-up value: cnt stays X until the first reset or load.
   always_ff @(posedge clk) begin
      unique case (op)
         OP_RST:   cnt <= '0;
         OP_LOAD:  cnt <= d;
         OP_COUNT: cnt <= nxt;
         default:  cnt <= cnt;
      endcase
   end

   assign rco_i = et & term;

`ifdef LSTTL_CNT_TIMING_EN
   assign #(tPLH_min:tPLH_typ:tPLH_max, tPHL_min:tPHL_typ:tPHL_max)
      q = cnt;
   assign #(tPLHR_min:tPLHR_typ:tPLHR_max, tPHLR_min:tPHLR_typ:tPHLR_max)
      rco = rco_i;
`else
   assign q   = cnt;
   assign rco = rco_i;
`endif

endmodule
